// File: rtl/geofence_pkg.sv
// geofence_pkg: shared types and widths for the convex-polygon geofence engine.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the FSM encoding, default geometry widths and signed arithmetic typedefs.
package geofence_pkg;

  // Default geometry: 10-bit unsigned coordinates, 6-vertex fence.
  localparam int GEO_CW = 10;
  localparam int GEO_NV = 6;

  // IW counts samples 0..NV, DW is a signed coordinate difference,
  // XW is a signed cross product of two DW vectors.
  localparam int IW = $clog2(GEO_NV + 1);
  localparam int DW = GEO_CW + 1;
  localparam int XW = 2 * GEO_CW + 3;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    TEST = 2'd2,
    DONE = 2'd3
  } geo_state_t;

  typedef logic signed [DW-1:0] diff_t;
  typedef logic signed [XW-1:0] cross_t;

endpackage

// File: rtl/geofence_poly_if.sv
// geofence_poly_if: sample stream in, result strobe out, for geofence_poly.
// Latency: n/a (wiring only). Backpressure: in_ready gates X/Y acceptance.
// master = point source / result sink, slave = geofence_poly.
// Ports: X, Y, in_valid (to slave); in_ready, valid, is_inside, on_edge (from slave);
//        area (from slave) only when GEOFENCE_AREA_EN is defined.
interface geofence_poly_if #(
  parameter int CW = 10
);
  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic          in_valid;
  logic          in_ready;
  logic          valid;
  logic          is_inside;
  logic          on_edge;
`ifdef GEOFENCE_AREA_EN
  logic [2*CW-1:0] area;

  modport master (output X, Y, in_valid, input in_ready, valid, is_inside, on_edge, area);
  modport slave  (input X, Y, in_valid, output in_ready, valid, is_inside, on_edge, area);
`else
  modport master (output X, Y, in_valid, input in_ready, valid, is_inside, on_edge);
  modport slave  (input X, Y, in_valid, output in_ready, valid, is_inside, on_edge);
`endif
endinterface

// File: rtl/geofence_cross.sv
// geofence_cross: combinational signed 2-D cross product c = a.x*b.y - a.y*b.x.
// Latency: 0 cycles (purely combinational). Backpressure: none.
// Ports: ax, ay, bx, by signed DW-bit vector components; c signed 2*DW+1-bit result.
module geofence_cross #(
  parameter int DW = geofence_pkg::DW
) (
  input  logic signed [DW-1:0] ax,
  input  logic signed [DW-1:0] ay,
  input  logic signed [DW-1:0] bx,
  input  logic signed [DW-1:0] by,
  output logic signed [2*DW:0] c
);

  logic signed [2*DW-1:0] p0;
  logic signed [2*DW-1:0] p1;

  assign p0 = ax * by;
  assign p1 = ay * bx;

  // One extra bit so the difference of two full-range products cannot wrap.
  assign c = $signed({p0[2*DW-1], p0}) - $signed({p1[2*DW-1], p1});

endmodule

// File: rtl/geofence_poly.sv
// geofence_poly: point-in-convex-polygon test over a streamed target + NV vertices.
// Latency: valid in cycle (NV-1)(NV-2)/2 + NV + 2 after the last accepted sample.
// Backpressure: in_ready high only while loading; no samples accepted while busy.
// Ports: clk, reset (async active-high), bus (geofence_poly_if.slave: X, Y, in_valid,
//        in_ready, valid, is_inside, on_edge, plus area when GEOFENCE_AREA_EN is defined).
// Optional feature macro: GEOFENCE_AREA_EN adds the shoelace area output.
module geofence_poly
  import geofence_pkg::*;
#(
  parameter int CW = GEO_CW,
  parameter int NV = GEO_NV
) (
  input  logic           clk,
  input  logic           reset,
  geofence_poly_if.slave bus
);

  localparam int IWL = $clog2(NV + 1);
  localparam int AW  = $clog2(NV);
  localparam int DWL = CW + 1;
  localparam int XWL = 2 * CW + 3;

  geo_state_t     state_q;
  logic [IWL-1:0] cnt_q;
  logic [AW-1:0]  a_q;
  logic [AW-1:0]  b_q;
  logic [AW-1:0]  k_q;
  logic           perm_q;
  logic [AW-1:0]  rank_q [NV];
  logic [CW-1:0]  px_q;
  logic [CW-1:0]  py_q;
  logic [CW-1:0]  vx_q [NV];
  logic [CW-1:0]  vy_q [NV];
  logic           neg_q;
  logic           zer_q;
  logic           valid_q;
  logic           inside_q;
  logic           edge_q;

  logic           accept;
  logic [AW-1:0]  kn;
  logic [CW-1:0]  wx [NV];
  logic [CW-1:0]  wy [NV];

  logic signed [DWL-1:0] op_ax;
  logic signed [DWL-1:0] op_ay;
  logic signed [DWL-1:0] op_bx;
  logic signed [DWL-1:0] op_by;
  logic signed [XWL-1:0] cr;
  logic                  cr_pos;
  logic                  neg_n;
  logic                  zer_n;

  function automatic logic signed [DWL-1:0] sub(input logic [CW-1:0] p, input logic [CW-1:0] q);
    return $signed({1'b0, p}) - $signed({1'b0, q});
  endfunction

  assign bus.in_ready  = (state_q == LOAD);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.valid     = valid_q;
  assign bus.is_inside = inside_q;
  assign bus.on_edge   = edge_q;

  // Successor vertex index with the wrap edge back to w_0.
  assign kn = (k_q == AW'(NV - 1)) ? '0 : k_q + 1'b1;

  // One cross-product unit is shared: SORT compares two pivot-relative vertices,
  // TEST takes the edge vector against the target offset.
  always_comb begin
    op_ax = '0;
    op_ay = '0;
    op_bx = '0;
    op_by = '0;
    if (state_q == SORT) begin
      op_ax = sub(vx_q[a_q], vx_q[0]);
      op_ay = sub(vy_q[a_q], vy_q[0]);
      op_bx = sub(vx_q[b_q], vx_q[0]);
      op_by = sub(vy_q[b_q], vy_q[0]);
    end else begin
      op_ax = sub(vx_q[kn], vx_q[k_q]);
      op_ay = sub(vy_q[kn], vy_q[k_q]);
      op_bx = sub(px_q, vx_q[k_q]);
      op_by = sub(py_q, vy_q[k_q]);
    end
  end

  geofence_cross #(.DW(DWL)) u_cross (
    .ax (op_ax),
    .ay (op_ay),
    .bx (op_bx),
    .by (op_by),
    .c  (cr)
  );

  assign cr_pos = ~cr[XWL-1] & (cr != '0);
  assign neg_n  = neg_q | cr[XWL-1];
  assign zer_n  = zer_q | (cr == '0);

  // Rank r means r vertices precede this one counter-clockwise around the pivot,
  // so vertex i lands in slot rank+1; the pivot keeps slot 0.
  always_comb begin
    for (int j = 0; j < NV; j++) begin
      wx[j] = '0;
      wy[j] = '0;
    end
    wx[0] = vx_q[0];
    wy[0] = vy_q[0];
    for (int j = 1; j < NV; j++) begin
      for (int i = 1; i < NV; i++) begin
        if (rank_q[i] == AW'(j - 1)) begin
          wx[j] = vx_q[i];
          wy[j] = vy_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      perm_q   <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      neg_q    <= 1'b0;
      zer_q    <= 1'b0;
      valid_q  <= 1'b0;
      inside_q <= 1'b0;
      edge_q   <= 1'b0;
      for (int i = 0; i < NV; i++) begin
        rank_q[i] <= '0;
        vx_q[i]   <= '0;
        vy_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (cnt_q == '0) begin
              px_q <= bus.X;
              py_q <= bus.Y;
            end
            for (int i = 0; i < NV; i++) begin
              if (cnt_q == IWL'(i + 1)) begin
                vx_q[i] <= bus.X;
                vy_q[i] <= bus.Y;
              end
            end
            if (cnt_q == IWL'(NV)) begin
              cnt_q   <= '0;
              a_q     <= AW'(1);
              b_q     <= AW'(2);
              perm_q  <= 1'b0;
              state_q <= SORT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        SORT: begin
          if (perm_q) begin
            for (int j = 0; j < NV; j++) begin
              vx_q[j] <= wx[j];
              vy_q[j] <= wy[j];
            end
            k_q     <= '0;
            state_q <= TEST;
          end else begin
            // Positive cross: vb lies counter-clockwise of va, so vb sorts later.
            if (cr_pos) begin
              rank_q[b_q] <= rank_q[b_q] + 1'b1;
            end else begin
              rank_q[a_q] <= rank_q[a_q] + 1'b1;
            end
            if (b_q == AW'(NV - 1)) begin
              if (a_q == AW'(NV - 2)) begin
                perm_q <= 1'b1;
              end else begin
                a_q <= a_q + 1'b1;
                b_q <= a_q + AW'(2);
              end
            end else begin
              b_q <= b_q + 1'b1;
            end
          end
        end

        TEST: begin
          neg_q <= neg_n;
          zer_q <= zer_n;
          if (k_q == AW'(NV - 1)) begin
            valid_q  <= 1'b1;
            inside_q <= ~neg_n;
            edge_q   <= ~neg_n & zer_n;
            state_q  <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end

        DONE: begin
          valid_q  <= 1'b0;
          inside_q <= 1'b0;
          edge_q   <= 1'b0;
          cnt_q    <= '0;
          a_q      <= '0;
          b_q      <= '0;
          k_q      <= '0;
          perm_q   <= 1'b0;
          neg_q    <= 1'b0;
          zer_q    <= 1'b0;
          for (int i = 0; i < NV; i++) begin
            rank_q[i] <= '0;
          end
          state_q <= LOAD;
        end

        default: state_q <= LOAD;
      endcase
    end
  end

`ifdef GEOFENCE_AREA_EN
  // Twice the signed area accumulates as sum of x_k*y_(k+1) - x_(k+1)*y_k over the
  // sorted (counter-clockwise, hence non-negative) vertex order.
  logic signed [DWL-1:0]   ar_ax;
  logic signed [DWL-1:0]   ar_ay;
  logic signed [DWL-1:0]   ar_bx;
  logic signed [DWL-1:0]   ar_by;
  logic signed [XWL-1:0]   ar_term;
  logic signed [XWL+2:0]   acc_q;
  logic signed [XWL+2:0]   acc_n;
  logic [2*CW-1:0]         area_q;

  assign ar_ax = $signed({1'b0, vx_q[k_q]});
  assign ar_ay = $signed({1'b0, vy_q[k_q]});
  assign ar_bx = $signed({1'b0, vx_q[kn]});
  assign ar_by = $signed({1'b0, vy_q[kn]});

  geofence_cross #(.DW(DWL)) u_area_cross (
    .ax (ar_ax),
    .ay (ar_ay),
    .bx (ar_bx),
    .by (ar_by),
    .c  (ar_term)
  );

  assign acc_n    = acc_q + $signed({{3{ar_term[XWL-1]}}, ar_term});
  assign bus.area = area_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      area_q <= '0;
    end else begin
      case (state_q)
        TEST: begin
          acc_q <= acc_n;
          if (k_q == AW'(NV - 1)) begin
            area_q <= acc_n[2*CW:1];
          end
        end
        DONE: begin
          acc_q  <= '0;
          area_q <= '0;
        end
        default: begin
          acc_q  <= acc_q;
          area_q <= area_q;
        end
      endcase
    end
  end
`endif

endmodule
